// File: rtl/sdram_word_adapter.sv
// Splits 32-bit word requests into byte transactions for sdram_core and
// reassembles read bytes into one word response.
//
// state   | meaning
// IDLE    | ready for a word request
// WR_BYTE | core write of the current enabled lane outstanding
// RD_BYTE | core read of the current lane requested, waiting for accept
// RD_WAIT | read accepted, waiting for core_ack
// RESP    | one-cycle completion pulse
module sdram_word_adapter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic [7:0]            core_write_data,
  output logic                  core_wr,
  output logic                  core_rd,
  input  logic                  core_accept,
  input  logic                  core_ack,
  input  logic [7:0]            core_read_data
);

  typedef enum logic [2:0] {IDLE, WR_BYTE, RD_BYTE, RD_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] base_q, base_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [3:0]            higher_be;
  logic [31:0]           rdata_d;
  logic                  req_ready_d, core_wr_d, core_rd_d, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] core_addr_d;
  logic [7:0]            core_write_data_d;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    lane_d    = lane_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rsp_rdata;
    higher_be = be_q & (4'b1110 << lane_q);
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          base_d  = req_addr[ADDR_WIDTH-1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          rdata_d = '0;
          lane_d  = 2'd0;
          if (!req_we)              state_d = RD_BYTE;
          else if (req_be != 4'h0) begin
            state_d = WR_BYTE;
            lane_d  = lowest_lane(req_be);
          end
          else                      state_d = RESP;
        end
      end
      WR_BYTE: begin
        if (core_accept) begin
          if (higher_be != 4'h0) lane_d  = lowest_lane(higher_be);
          else                   state_d = RESP;
        end
      end
      RD_BYTE: if (core_accept) state_d = RD_WAIT;
      RD_WAIT: begin
        if (core_ack) begin
          rdata_d[{lane_q, 3'b000} +: 8] = core_read_data;
          if (lane_q == 2'd3) state_d = RESP;
          else begin
            lane_d  = lane_q + 2'd1;
            state_d = RD_BYTE;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    req_ready_d       = (state_d == IDLE);
    core_wr_d         = (state_d == WR_BYTE);
    core_rd_d         = (state_d == RD_BYTE);
    rsp_valid_d       = (state_d == RESP);
    core_addr_d       = (core_wr_d || core_rd_d) ? {base_d, lane_d} : '0;
    core_write_data_d = core_wr_d ? wdata_d[{lane_d, 3'b000} +: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      base_q          <= '0;
      lane_q          <= 2'd0;
      wdata_q         <= '0;
      be_q            <= '0;
      req_ready       <= 1'b0;
      core_wr         <= 1'b0;
      core_rd         <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      core_addr       <= '0;
      core_write_data <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      lane_q          <= lane_d;
      wdata_q         <= wdata_d;
      be_q            <= be_d;
      req_ready       <= req_ready_d;
      core_wr         <= core_wr_d;
      core_rd         <= core_rd_d;
      rsp_valid       <= rsp_valid_d;
      rsp_rdata       <= rdata_d;
      core_addr       <= core_addr_d;
      core_write_data <= core_write_data_d;
    end
  end

endmodule
